// File: rtl/ifu.sv
// ============================================================================
// Module   : ifu
// Purpose  : Instruction fetch unit. Pipelined imem requests with credit-based
//            flow control, in-order response queue, redirect flush/drop.
//            Optional macro IFU_BYPASS_EN: empty-queue response bypass to decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu #(
    parameter int                XLEN     = 64,
    parameter int                DEPTH    = 4,
    parameter logic [XLEN-1:0]   RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc
);

    localparam int              c_PW   = $clog2(DEPTH);
    localparam int              c_CW   = c_PW + 1;
    localparam logic [c_CW:0]   c_FULL = (c_CW + 1)'(DEPTH);
    localparam logic [31:0]     c_NOP  = 32'h0000_0013;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [31:0]     r_q_instr [DEPTH];
    logic [XLEN-1:0] r_q_pc    [DEPTH];
    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [c_CW-1:0] r_count;
    logic [c_CW-1:0] r_inflight;
    logic [c_CW-1:0] r_drop;

    logic            w_credit_ok;
    logic            w_req_hs;
    logic            w_resp_keep;
    logic            w_q_empty;
    logic            w_bypass;
    logic            w_pop;
    logic            w_q_pop;
    logic            w_push;
    logic [XLEN-1:0] w_redir_pc;

    // Queued plus outstanding instructions never exceed DEPTH, so every
    // response is guaranteed a free slot.
    assign w_credit_ok    = ({1'b0, r_inflight} + {1'b0, r_count}) < c_FULL;
    assign imem_req_valid = !rst && !redirect_valid && w_credit_ok;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_hs       = imem_req_valid && imem_req_ready;
    assign w_redir_pc     = redirect_pc & ~XLEN'(3);

    assign w_resp_keep    = imem_resp_valid && (r_drop == '0) && !redirect_valid;
    assign w_q_empty      = (r_count == '0);

`ifdef IFU_BYPASS_EN
    assign w_bypass       = w_q_empty && w_resp_keep;
`else
    assign w_bypass       = 1'b0;
`endif

    assign instr_valid    = !w_q_empty || w_bypass;
    assign w_pop          = instr_valid && instr_ready && !redirect_valid;
    assign w_q_pop        = w_pop && !w_q_empty;
    assign w_push         = w_resp_keep && !(w_bypass && instr_ready);

    always_comb begin
        instr    = c_NOP;
        instr_pc = '0;
        if (!w_q_empty) begin
            instr    = r_q_instr[r_head];
            instr_pc = r_q_pc[r_head];
        end else if (w_bypass) begin
            instr    = imem_resp_instr;
            instr_pc = r_resp_pc;
        end
    end

    // r_resp_pc is the address of the next kept response: the stream is
    // sequential from the last redirect, and all older responses are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redir_pc;
            r_resp_pc  <= w_redir_pc;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inflight <= r_inflight - c_CW'(imem_resp_valid);
            r_drop     <= r_inflight - c_CW'(imem_resp_valid);
        end else begin
            if (w_req_hs)
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            if (w_resp_keep)
                r_resp_pc <= r_resp_pc + XLEN'(4);
            r_inflight <= r_inflight + c_CW'(w_req_hs) - c_CW'(imem_resp_valid);
            if (imem_resp_valid && (r_drop != '0))
                r_drop <= r_drop - c_CW'(1);
            if (w_push)
                r_tail <= r_tail + c_PW'(1);
            if (w_q_pop)
                r_head <= r_head + c_PW'(1);
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_q_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_tail] <= imem_resp_instr;
            r_q_pc[r_tail]    <= r_resp_pc;
        end
    end

    a_resp_has_slot: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> ((r_inflight != '0) &&
                             ((r_drop != '0) || redirect_valid || (r_count != c_CW'(DEPTH)))));

endmodule

`default_nettype wire
